// File: rtl/mod_n_updown_counter_pkg.sv
// Shared encodings for the modulo-N up/down counter: mode field values and
// the one-shot sequencer states.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle of one counter stage; the counter sits on the slave
// side, whatever sequences it sits on the master side.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 3
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [1:0]       mode;
    logic             start;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             running;
    logic             done;

    modport master (
        output enable, up_down, load, load_value, mode, start,
        input  out, carry_out, running, done
    );

    modport slave (
        input  enable, up_down, load, load_value, mode, start,
        output out, carry_out, running, done
    );
endinterface

// File: rtl/mod_n_updown_counter_step.sv
// Next-count and terminal-count logic for one modulo-N stage. The wrap is an
// explicit compare so non-power-of-two moduli never leave 0..MODULUS-1.
module mod_n_step
    import counter_pkg::*;
#(
    parameter int MODULUS = 8,
    parameter int WIDTH   = 3
) (
    input  logic [WIDTH-1:0] count_in,
    input  logic             up_down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count_next,
    output logic             at_limit
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic hold;

    always_comb begin
        at_limit   = up_down ? (count_in == MAX_VAL) : (count_in == '0);
        // saturate and one-shot both park on the limit instead of wrapping
        hold       = at_limit && ((mode == MODE_SAT) || (mode == MODE_ONESHOT));
        count_next = count_in;
        if (!hold) begin
            if (up_down) count_next = at_limit ? '0 : count_in + WIDTH'(1);
            else         count_next = at_limit ? MAX_VAL : count_in - WIDTH'(1);
        end
    end
endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with parallel load, wrap/saturate/one-shot modes
// and a zero-latency cascade carry.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | one-shot not armed (or not in one-shot mode)
//   ST_RUN  | one-shot armed, counting on enable
//   ST_DONE | one-shot reached its limit, count parked
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 8,
    parameter int WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    mod_n_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;
    logic             at_limit;
    logic             oneshot;
    logic             count_ok;
    state_t           state;
    logic             running_q;
    logic             done_q;

    mod_n_step #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_step (
        .count_in   (count_q),
        .up_down    (bus.up_down),
        .mode       (bus.mode),
        .count_next (count_next),
        .at_limit   (at_limit)
    );

    assign oneshot      = (bus.mode == MODE_ONESHOT);
    assign count_ok     = bus.enable && (!oneshot || (state == ST_RUN));
    assign load_clamped = ({1'b0, bus.load_value} < MOD_EXT) ? bus.load_value : MAX_VAL;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            state     <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (bus.load)                  count_q <= load_clamped;
            else if (oneshot && bus.start) count_q <= bus.up_down ? '0 : MAX_VAL;
            else if (count_ok)             count_q <= count_next;

            // a load freezes the sequencer; leaving one-shot mode always disarms it
            if (!oneshot) begin
                state     <= ST_IDLE;
                running_q <= 1'b0;
                done_q    <= 1'b0;
            end else if (!bus.load) begin
                if (bus.start) begin
                    state     <= ST_RUN;
                    running_q <= 1'b1;
                    done_q    <= 1'b0;
                end else if ((state == ST_RUN) && bus.enable && at_limit) begin
                    state     <= ST_DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.out       = count_q;
    assign bus.carry_out = bus.enable & at_limit;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench: a mod-8 stage plus a cascaded pair of mod-10 stages,
// compared cycle by cycle against an arithmetic reference model.
module tb_mod_n_updown_counter;

    typedef struct {
        bit en;
        bit ud;
        bit ld;
        int lv;
        int md;
        bit st;
    } in_t;

    typedef struct {
        bit c0, c1, c2;
        int o0, o1, o2;
        bit r0, r1, r2;
        bit d0, d1, d2;
    } exp_t;

    logic clk = 1'b0;
    logic rst8, rst10;
    always #5 clk = ~clk;

    mod_n_updown_counter_if #(.WIDTH(3)) bus8 ();
    mod_n_updown_counter_if #(.WIDTH(4)) bus10a ();
    mod_n_updown_counter_if #(.WIDTH(4)) bus10b ();

    mod_n_updown_counter #(.MODULUS(8),  .WIDTH(3)) dut8   (.clk(clk), .reset(rst8),  .bus(bus8.slave));
    mod_n_updown_counter #(.MODULUS(10), .WIDTH(4)) dut10a (.clk(clk), .reset(rst10), .bus(bus10a.slave));
    mod_n_updown_counter #(.MODULUS(10), .WIDTH(4)) dut10b (.clk(clk), .reset(rst10), .bus(bus10b.slave));

    assign bus10b.enable = bus10a.carry_out;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m8c = 0, m8p = 0, mac = 0, map = 0, mbc = 0, mbp = 0;

    function automatic in_t mk(bit en, bit ud, bit ld, int lv, int md, bit st);
        in_t r;
        r.en = en; r.ud = ud; r.ld = ld; r.lv = lv; r.md = md; r.st = st;
        return r;
    endfunction

    // Reference: phase 0 = idle, 1 = run, 2 = done
    task automatic mstep(input int m, input bit rst, input in_t i,
                         inout int cnt, inout int ph, output bit carry);
        bit lim;
        lim   = i.ud ? (cnt == m - 1) : (cnt == 0);
        carry = i.en && lim;
        if (rst) begin
            cnt = 0;
            ph  = 0;
        end else begin
            if (i.ld) cnt = (i.lv < m) ? i.lv : m - 1;
            else if (i.md == 2 && i.st) begin
                ph  = 1;
                cnt = i.ud ? 0 : m - 1;
            end else if (i.en) begin
                if (i.md == 1) begin
                    if (!lim) cnt = i.ud ? cnt + 1 : cnt - 1;
                end else if (i.md == 2) begin
                    if (ph == 1) begin
                        if (lim) ph = 2;
                        else     cnt = i.ud ? cnt + 1 : cnt - 1;
                    end
                end else begin
                    cnt = i.ud ? (cnt + 1) % m : (cnt + m - 1) % m;
                end
            end
            if (i.md != 2) ph = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r8, input in_t a, input bit r10, input in_t b, input bit push);
        exp_t e;
        bit   c8, ca, cb;
        in_t  bb;
        @(negedge clk);
        rst8  = r8;
        rst10 = r10;
        bus8.enable = a.en;   bus8.up_down = a.ud; bus8.load = a.ld;
        bus8.load_value = 3'(a.lv); bus8.mode = 2'(a.md); bus8.start = a.st;
        bus10a.enable = b.en; bus10a.up_down = b.ud; bus10a.load = b.ld;
        bus10a.load_value = 4'(b.lv); bus10a.mode = 2'(b.md); bus10a.start = b.st;
        mstep(8, r8, a, m8c, m8p, c8);
        mstep(10, r10, b, mac, map, ca);
        bb = mk(ca, 1'b1, 1'b0, 0, 0, 1'b0);
        mstep(10, r10, bb, mbc, mbp, cb);
        e.c0 = c8;  e.o0 = m8c; e.r0 = (m8p == 1); e.d0 = (m8p == 2);
        e.c1 = ca;  e.o1 = mac; e.r1 = (map == 1); e.d1 = (map == 2);
        e.c2 = cb;  e.o2 = mbc; e.r2 = (mbp == 1); e.d2 = (mbp == 2);
        if (push) q.push_back(e);
    endtask

    // Monitor: carry sampled mid-low-phase, registered outputs after the edge
    initial begin
        logic s8, sa, sb;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            s8 = bus8.carry_out; sa = bus10a.carry_out; sb = bus10b.carry_out;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("carry8",  32'(s8), 32'(e.c0));
                chk("out8",    32'(bus8.out), e.o0);
                chk("run8",    32'(bus8.running), 32'(e.r0));
                chk("done8",   32'(bus8.done), 32'(e.d0));
                chk("carry10a", 32'(sa), 32'(e.c1));
                chk("out10a",  32'(bus10a.out), e.o1);
                chk("run10a",  32'(bus10a.running), 32'(e.r1));
                chk("done10a", 32'(bus10a.done), 32'(e.d1));
                chk("carry10b", 32'(sb), 32'(e.c2));
                chk("out10b",  32'(bus10b.out), e.o2);
                chk("run10b",  32'(bus10b.running), 32'(e.r2));
                chk("done10b", 32'(bus10b.done), 32'(e.d2));
            end
        end
    end

    initial begin
        in_t idle, a, b;
        int  md8, md10;
        idle = mk(0, 1, 0, 0, 0, 0);
        rst8 = 1'b1; rst10 = 1'b1;
        bus8.enable = 0; bus8.up_down = 1; bus8.load = 0; bus8.load_value = '0; bus8.mode = '0; bus8.start = 0;
        bus10a.enable = 0; bus10a.up_down = 1; bus10a.load = 0; bus10a.load_value = '0; bus10a.mode = '0; bus10a.start = 0;
        bus10b.up_down = 1; bus10b.load = 0; bus10b.load_value = '0; bus10b.mode = '0; bus10b.start = 0;

        repeat (2) drive(1, idle, 1, idle, 0);
        drive(1, idle, 1, idle, 1);
        drive(0, idle, 0, idle, 1);

        // mod-8 wrap up
        repeat (10) drive(0, mk(1, 1, 0, 0, 0, 0), 0, idle, 1);

        // mod-10 wrap down from a load, then clamped load
        drive(0, idle, 0, mk(0, 0, 1, 3, 0, 0), 1);
        repeat (5) drive(0, idle, 0, mk(1, 0, 0, 0, 0, 0), 1);
        drive(0, idle, 0, mk(0, 0, 1, 12, 0, 0), 1);

        // saturate up from 5, then down
        drive(0, mk(0, 1, 1, 5, 1, 0), 0, idle, 1);
        repeat (5) drive(0, mk(1, 1, 0, 0, 1, 0), 0, idle, 1);
        repeat (2) drive(0, mk(1, 0, 0, 0, 1, 0), 0, idle, 1);

        // one-shot up, run to done, restart
        drive(0, mk(0, 1, 0, 0, 2, 0), 0, idle, 1);
        drive(0, mk(0, 1, 0, 0, 2, 1), 0, idle, 1);
        repeat (10) drive(0, mk(1, 1, 0, 0, 2, 0), 0, idle, 1);
        drive(0, mk(0, 1, 0, 0, 2, 1), 0, idle, 1);
        repeat (3) drive(0, mk(1, 1, 0, 0, 2, 0), 0, idle, 1);

        // reset mid-run, then load+start together
        drive(0, mk(0, 1, 0, 0, 2, 1), 0, idle, 1);
        repeat (5) drive(0, mk(1, 1, 0, 0, 2, 0), 0, idle, 1);
        drive(1, mk(1, 1, 0, 0, 2, 0), 0, idle, 1);
        drive(0, mk(0, 1, 0, 0, 2, 1), 0, idle, 1);
        drive(0, mk(0, 1, 1, 3, 2, 1), 0, idle, 1);
        drive(0, mk(0, 0, 0, 0, 2, 0), 0, idle, 1);

        // one-shot down
        drive(0, mk(0, 0, 0, 0, 2, 1), 0, idle, 1);
        repeat (9) drive(0, mk(1, 0, 0, 0, 2, 0), 0, idle, 1);

        // cascade of two mod-10 stages
        drive(0, idle, 1, idle, 1);
        repeat (25) drive(0, idle, 0, mk(1, 1, 0, 0, 0, 0), 1);
        drive(0, idle, 0, idle, 1);

        // randomized traffic, mode held for segments so one-shot runs get long
        md8 = 0; md10 = 0;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                md8  = int'($urandom_range(0, 3));
                md10 = int'($urandom_range(0, 3));
            end
            a = mk(1'($urandom), 1'($urandom), $urandom_range(0, 11) == 0,
                   int'($urandom_range(0, 7)), md8, $urandom_range(0, 15) == 0);
            b = mk(1'($urandom), 1'($urandom), $urandom_range(0, 11) == 0,
                   int'($urandom_range(0, 15)), md10, $urandom_range(0, 15) == 0);
            drive($urandom_range(0, 79) == 0, a, $urandom_range(0, 79) == 0, b, 1);
        end

        drive(0, idle, 0, idle, 1);
        for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
        #3;
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
Parametrised modulo-N counter, successor to the fixed mod-8 up counter.
- Adds up/down direction, synchronous parallel load, wrap/saturate/one-shot modes and a cascade carry output.
- Used as a general-purpose timebase, divider and event counter. Instances chain through carry_out into the next stage's enable.

Parameters:
- MODULUS, 8, count range is 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- WIDTH, 3, width of the count and load ports.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; also the cascade input.
- up_down  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value taken on load.
- mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap).
- start  input  1  one-shot arm/restart strobe; ignored in other modes.
- out  output  WIDTH  current count (registered).
- carry_out  output  1  combinational: enable & at_limit.
- running  output  1  registered; one-shot FSM is in RUN.
- done  output  1  registered; one-shot FSM is in DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset state: out = 0, FSM = IDLE, running = 0, done = 0. carry_out follows from these values and enable.
- at_limit definition: (up_down & out == MODULUS-1) | (~up_down & out == 0).
- Priority per edge: reset > load > start > count.
- Load:
  - out <= load_value if load_value < MODULUS, otherwise out <= MODULUS-1.
  - Load does not change the FSM state.
  - Takes effect regardless of enable.
- Counting (only when enable = 1 and no load or start this cycle):
  - Wrap: up count goes MODULUS-1 -> 0; down count goes 0 -> MODULUS-1; otherwise ±1.
  - Saturate: out holds at the limit; otherwise ±1.
  - One-shot: counts only in RUN. When out is at_limit with enable = 1, out holds and the FSM goes RUN -> DONE.
- One-shot FSM (IDLE / RUN / DONE):
  - IDLE: out holds even when enable = 1. start -> RUN, with out <= 0 (up) or MODULUS-1 (down).
  - RUN: counts on enable. Reaching the limit as described above -> DONE. start restarts: out is reinitialised and the FSM stays in RUN.
  - DONE: out holds. start -> RUN with out reinitialised.
  - Any mode other than 10 forces the FSM to IDLE on the next edge; running and done clear.
- Latency:
  - out updates one edge after the qualifying inputs.
  - carry_out has zero latency: it is asserted in the same cycle as the terminal count so that a downstream stage advances on the same edge this stage wraps.
- Direction change takes effect on the same edge; no pipeline.
- Reset asserted mid-count or mid-one-shot returns every register to its reset value on that edge.
- Non-power-of-two MODULUS: out never leaves 0..MODULUS-1; the wrap compare is explicit, not natural overflow.
- Simultaneous load and start: load wins and start is dropped; the FSM state is unchanged.

Decomposition:
- Package counter_pkg:
  - Mode encoding constants: MODE_WRAP, MODE_SAT, MODE_ONESHOT.
  - FSM state typedef: ST_IDLE, ST_RUN, ST_DONE.
- Sub-module mod_n_step (combinational):
  - Inputs: out, up_down, mode.
  - Outputs: next value, at_limit.
- Top level holds the count register, load/clamp logic and the FSM.

Test Plan:
- MODULUS=8, wrap, up, enable = 1 for 10 cycles after reset -> out = 1,2,...,7,0,1,2; carry_out high only while out = 7.
- MODULUS=10, WIDTH=4, wrap, down, load_value = 3 -> out = 3,2,1,0,9,8; load_value = 12 -> out = 9 (clamped).
- MODULUS=8, saturate, up from 5 for 5 cycles -> out = 6,7,7,7,7. Switch to down -> 6,5.
- MODULUS=8, one-shot, up, start pulse then enable = 1 -> running = 1; out = 0..7 then holds at 7; done = 1 on the edge after out = 7 with enable = 1; further enable leaves out at 7. A second start -> out = 0, running = 1.
- Reset asserted while out = 5 in RUN -> next edge out = 0, running = 0, done = 0. With load = 1 and start = 1 in the same cycle -> out = load_value, FSM state unchanged.
- Cascade of two MODULUS=10 instances (stage 0 carry_out drives stage 1 enable), 25 enabled cycles -> stage 1 out = 2, stage 0 out = 5.
